// File: rtl/dbg_ram_rd_ctrl.sv
// Read-side controller for the debug capture RAM: issues port-b reads and returns
// the captured words as a valid/ready stream through a 2-entry fall-through buffer.
module dbg_ram_rd_ctrl #(
  parameter int RAM_DEPTH  = 4096,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_WIDTH:0] start_addr,
  input  logic [ADDR_WIDTH:0] rd_len,
  output logic                csb,
  output logic                wrb,
  output logic [ADDR_WIDTH:0] addrb,
  output logic [DATA_WIDTH:0] dinb,
  input  logic [DATA_WIDTH:0] doutb,
  output logic [DATA_WIDTH:0] dout,
  output logic                dout_vld,
  input  logic                dout_rdy,
  output logic                busy,
  output logic                done,
  output logic [1:0]          dbg_state
);

  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W   = AW1'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = AW1'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] ONE_A     = AW1'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e              state_q;
  logic [ADDR_WIDTH:0] cur_addr_q;
  logic [ADDR_WIDTH:0] remaining_q;
  logic [DATA_WIDTH:0] buf_q [2];
  logic [1:0]          occ_q;
  logic [1:0]          occ_d;
  logic [1:0]          occ_sum;
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic                inflight_q;
  logic                issue;
  logic                hs;
  logic                push;
  logic                pop;
  logic                last_word;

  // Stream handshake: a word transfers in any cycle where dout_vld && dout_rdy;
  // dout holds steady while dout_vld is high and dout_rdy is low.
  // An in-flight word with an empty buffer is presented straight from doutb,
  // which is what gives first data two cycles after start.
  always_comb begin
    occ_sum   = occ_q + {1'b0, inflight_q};
    issue     = (state_q == READ) && (remaining_q != '0) && (occ_sum < 2'd2);
    dout_vld  = (occ_q != 2'd0) || inflight_q;
    if (occ_q != 2'd0) begin
      dout = buf_q[rd_ptr_q];
    end else if (inflight_q) begin
      dout = doutb;
    end else begin
      dout = '0;
    end
    hs        = dout_vld && dout_rdy;
    pop       = hs && (occ_q != 2'd0);
    push      = inflight_q && !(hs && (occ_q == 2'd0));
    last_word = (state_q == DRAIN) && (occ_sum == 2'd1);
    done      = hs && last_word && !abort;
    occ_d     = occ_q + {1'b0, push} - {1'b0, pop};
  end

  assign csb       = issue;
  assign wrb       = 1'b0;
  assign dinb      = '0;
  assign addrb     = cur_addr_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      occ_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      inflight_q  <= 1'b0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
    end else if (abort) begin
      // Dropping inflight_q discards the read whose data arrives next cycle.
      state_q    <= IDLE;
      occ_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      occ_q      <= occ_d;
      if (push) begin
        buf_q[wr_ptr_q] <= doutb;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            cur_addr_q  <= start_addr;
            remaining_q <= (rd_len == '0) ? DEPTH_W : rd_len;
            state_q     <= READ;
          end
        end
        READ: begin
          if (issue) begin
            cur_addr_q  <= (cur_addr_q == LAST_ADDR) ? '0 : cur_addr_q + ONE_A;
            remaining_q <= remaining_q - ONE_A;
            if (remaining_q == ONE_A) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (done) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
